// File: rtl/agex_pkg.sv
// Shared encodings for the AGEX execute stage: ALU op codes, flag bit
// positions inside out_flags, ModRM mod values and the execute FSM states.
package agex_pkg;

    // ALU op encodings carried on in_aluk
    localparam logic [2:0] ALUK_ADD = 3'b000;
    localparam logic [2:0] ALUK_OR  = 3'b001;
    localparam logic [2:0] ALUK_AND = 3'b010;
    localparam logic [2:0] ALUK_XOR = 3'b011;
    localparam logic [2:0] ALUK_SUB = 3'b100;
    localparam logic [2:0] ALUK_SHR = 3'b101;
    localparam logic [2:0] ALUK_SHL = 3'b110;
    localparam logic [2:0] ALUK_SAR = 3'b111;

    // Bit positions inside out_flags = {OF,SF,ZF,CF}
    localparam int FLAG_CF = 0;
    localparam int FLAG_ZF = 1;
    localparam int FLAG_SF = 2;
    localparam int FLAG_OF = 3;

    // ModRM mod field
    localparam logic [1:0] MOD_IND    = 2'b00;
    localparam logic [1:0] MOD_DISP8  = 2'b01;
    localparam logic [1:0] MOD_DISP32 = 2'b10;
    localparam logic [1:0] MOD_REG    = 2'b11;

    // r/m value that turns mod 00 into a displacement-only address
    localparam logic [2:0] RM_DISP_ONLY = 3'b101;

    // Execute FSM states
    localparam logic [0:0] ST_IDLE  = 1'b0;
    localparam logic [0:0] ST_SHIFT = 1'b1;

    // True for the three shift ops
    function automatic logic is_shift_op(input logic [2:0] aluk);
        return (aluk == ALUK_SHR) || (aluk == ALUK_SHL) || (aluk == ALUK_SAR);
    endfunction

endpackage

// File: rtl/agex_ea_gen.sv
// Combinational effective-address generator for ModRM-style addressing.
// Kept free of state so other pipeline stages can reuse it directly.
module agex_ea_gen
    import agex_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] src1,
    input  logic [WIDTH-1:0] disp,
    input  logic [1:0]       mod,
    input  logic [2:0]       rm,
    output logic [WIDTH-1:0] addr,
    output logic             addr_v
);

    // disp8 lives in the top byte of the displacement field
    logic [WIDTH-1:0] disp8_sext;
    assign disp8_sext = {{(WIDTH-8){disp[WIDTH-1]}}, disp[WIDTH-1:WIDTH-8]};

    // Select base/displacement combination from mod and r/m
    always_comb begin
        // NOTE: every output gets a default before the case so no path can infer a latch.
        addr   = '0;
        addr_v = 1'b1;
        case (mod)
            MOD_IND:    addr = (rm == RM_DISP_ONLY) ? disp : src1;
            MOD_DISP8:  addr = src1 + disp8_sext;
            MOD_DISP32: addr = src1 + disp;
            MOD_REG: begin
                addr   = '0;
                addr_v = 1'b0;
            end
            default: begin
                addr   = '0;
                addr_v = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/agex_exec_pipe.sv
// AGEX execute stage: single-cycle ALU, iterative multi-cycle shifter and
// effective-address generation feeding a one-entry valid/ready output register.
module agex_exec_pipe
    import agex_pkg::*;
#(
    parameter int WIDTH      = 32,
    parameter int SHAMT_W    = 5,
    parameter int SHIFT_STEP = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       in_aluk,
    input  logic [WIDTH-1:0] in_src1,
    input  logic [WIDTH-1:0] in_src2,
    input  logic [1:0]       in_mod,
    input  logic [2:0]       in_rm,
    input  logic [WIDTH-1:0] in_disp,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_result,
    output logic [WIDTH-1:0] out_addr,
    output logic             out_addr_v,
    output logic [3:0]       out_flags
);

    localparam int                 STEP_W  = SHAMT_W + 1;
    localparam logic [SHAMT_W:0]   STEP_N  = STEP_W'(SHIFT_STEP);
    localparam logic [SHAMT_W-1:0] MSB_IDX = SHAMT_W'(WIDTH - 1);

    // Shift engine state
    logic [0:0]         state_q;
    logic [WIDTH-1:0]   acc_q;
    logic [SHAMT_W-1:0] rem_q;
    logic [2:0]         op_q;
    logic [WIDTH-1:0]   addr_q;
    logic               addr_v_q;

    // Handshake
    logic accept, pop, out_free;
    logic in_is_shift, shift_start, alu_write;
    logic [SHAMT_W-1:0] shamt_in;

    assign shamt_in    = in_src2[SHAMT_W-1:0];
    assign out_free    = !out_valid || out_ready;
    assign in_ready    = !rst && (state_q == ST_IDLE) && out_free;
    assign accept      = in_valid && in_ready;
    assign pop         = out_valid && out_ready;
    assign in_is_shift = is_shift_op(in_aluk);
    assign shift_start = accept && in_is_shift && (shamt_in != '0);
    assign alu_write   = accept && !shift_start;

    // Effective address of the incoming request
    logic [WIDTH-1:0] ea_addr;
    logic             ea_addr_v;

    agex_ea_gen #(.WIDTH(WIDTH)) u_ea_gen (
        .src1   (in_src1),
        .disp   (in_disp),
        .mod    (in_mod),
        .rm     (in_rm),
        .addr   (ea_addr),
        .addr_v (ea_addr_v)
    );

    // Single-cycle ALU datapath
    logic [WIDTH:0]   sum_ext;
    logic [WIDTH-1:0] diff;
    logic [WIDTH-1:0] alu_result;
    logic             alu_cf, alu_of;

    assign sum_ext = {1'b0, in_src1} + {1'b0, in_src2};
    assign diff    = in_src1 - in_src2;

    // ALU result and arithmetic flags; shift-by-zero falls through to src1
    always_comb begin
        alu_result = in_src1;
        alu_cf     = 1'b0;
        alu_of     = 1'b0;
        case (in_aluk)
            ALUK_ADD: begin
                alu_result = sum_ext[WIDTH-1:0];
                alu_cf     = sum_ext[WIDTH];
                alu_of     = (in_src1[WIDTH-1] == in_src2[WIDTH-1]) &&
                             (sum_ext[WIDTH-1] != in_src1[WIDTH-1]);
            end
            ALUK_SUB: begin
                alu_result = diff;
                alu_cf     = in_src1 < in_src2;
                alu_of     = (in_src1[WIDTH-1] != in_src2[WIDTH-1]) &&
                             (diff[WIDTH-1] != in_src1[WIDTH-1]);
            end
            ALUK_OR:  alu_result = in_src1 | in_src2;
            ALUK_AND: alu_result = in_src1 & in_src2;
            ALUK_XOR: alu_result = in_src1 ^ in_src2;
            default:  alu_result = in_src1;
        endcase
    end

    // Iterative shifter: one step of up to SHIFT_STEP positions per cycle
    logic [SHAMT_W:0]   rem_ext, step_n;
    logic [SHAMT_W-1:0] step_n_m1;
    logic               step_last;
    logic [WIDTH-1:0]   acc_next;
    logic               shift_cf;
    logic               shift_fire, shift_done;

    assign rem_ext    = {1'b0, rem_q};
    assign step_last  = rem_ext <= STEP_N;
    assign step_n     = step_last ? rem_ext : STEP_N;
    assign step_n_m1  = SHAMT_W'(step_n - 1'b1);
    // The last step may only run when the output register can take the result
    assign shift_fire = (state_q == ST_SHIFT) && (!step_last || out_free);
    assign shift_done = shift_fire && step_last;

    // Shift the accumulator and pick the last bit shifted out
    always_comb begin
        acc_next = acc_q >> step_n;
        shift_cf = acc_q[step_n_m1];
        case (op_q)
            ALUK_SHL: begin
                acc_next = acc_q << step_n;
                shift_cf = acc_q[MSB_IDX - step_n_m1];
            end
            ALUK_SAR: acc_next = $signed(acc_q) >>> step_n;
            default:  acc_next = acc_q >> step_n;
        endcase
    end

    // Data written into the output register, from ALU or shifter
    logic             out_wr;
    logic [WIDTH-1:0] wr_result, wr_addr;
    logic             wr_addr_v;
    logic [3:0]       wr_flags;

    assign out_wr = alu_write || shift_done;

    always_comb begin
        wr_result = shift_done ? acc_next : alu_result;
        wr_addr   = shift_done ? addr_q   : ea_addr;
        wr_addr_v = shift_done ? addr_v_q : ea_addr_v;
        wr_flags  = '0;
        wr_flags[FLAG_ZF] = (wr_result == '0);
        wr_flags[FLAG_SF] = wr_result[WIDTH-1];
        wr_flags[FLAG_CF] = shift_done ? shift_cf : alu_cf;
        wr_flags[FLAG_OF] = shift_done ? 1'b0     : alu_of;
    end

    // FSM and shift operand registers
    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments so every register samples pre-edge values.
        if (rst) begin
            state_q  <= ST_IDLE;
            acc_q    <= '0;
            rem_q    <= '0;
            op_q     <= ALUK_ADD;
            addr_q   <= '0;
            addr_v_q <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (shift_start) begin
                        state_q  <= ST_SHIFT;
                        acc_q    <= in_src1;
                        rem_q    <= shamt_in;
                        op_q     <= in_aluk;
                        addr_q   <= ea_addr;
                        addr_v_q <= ea_addr_v;
                    end
                end
                ST_SHIFT: begin
                    if (shift_fire) begin
                        acc_q <= acc_next;
                        rem_q <= rem_q - step_n[SHAMT_W-1:0];
                    end
                    if (shift_done) begin
                        state_q <= ST_IDLE;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    // One-entry output register: load wins over pop, pop clears valid
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid  <= 1'b0;
            out_result <= '0;
            out_addr   <= '0;
            out_addr_v <= 1'b0;
            out_flags  <= '0;
        end else if (out_wr) begin
            out_valid  <= 1'b1;
            out_result <= wr_result;
            out_addr   <= wr_addr;
            out_addr_v <= wr_addr_v;
            out_flags  <= wr_flags;
        end else if (pop) begin
            out_valid  <= 1'b0;
        end
    end

endmodule

// File: tb/tb_agex_exec_pipe.sv
// Self-checking bench for agex_exec_pipe: directed vectors followed by
// randomized traffic, all compared against a transaction-level model.
module tb_agex_exec_pipe;

    localparam int WIDTH      = 32;
    localparam int SHAMT_W    = 5;
    localparam int SHIFT_STEP = 8;

    localparam logic [2:0] OP_ADD = 3'd0, OP_OR  = 3'd1, OP_AND = 3'd2, OP_XOR = 3'd3;
    localparam logic [2:0] OP_SUB = 3'd4, OP_SHR = 3'd5, OP_SHL = 3'd6, OP_SAR = 3'd7;

    logic             clk;
    logic             rst;
    logic             in_valid;
    logic             in_ready;
    logic [2:0]       in_aluk;
    logic [WIDTH-1:0] in_src1;
    logic [WIDTH-1:0] in_src2;
    logic [1:0]       in_mod;
    logic [2:0]       in_rm;
    logic [WIDTH-1:0] in_disp;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_result;
    logic [WIDTH-1:0] out_addr;
    logic             out_addr_v;
    logic [3:0]       out_flags;

    agex_exec_pipe #(
        .WIDTH      (WIDTH),
        .SHAMT_W    (SHAMT_W),
        .SHIFT_STEP (SHIFT_STEP)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_aluk    (in_aluk),
        .in_src1    (in_src1),
        .in_src2    (in_src2),
        .in_mod     (in_mod),
        .in_rm      (in_rm),
        .in_disp    (in_disp),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_result (out_result),
        .out_addr   (out_addr),
        .out_addr_v (out_addr_v),
        .out_flags  (out_flags)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Expected transaction and the cycle its result becomes visible
    typedef struct {
        logic [31:0] res;
        logic [31:0] addr;
        logic        addr_v;
        logic [3:0]  flags;
        int          t_ready;
    } exp_t;

    exp_t q[$];
    int   cyc        = 0;
    int   busy_until = 0;
    int   total      = 0;
    int   bad        = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Architectural result of one request, computed from the op definitions
    function automatic exp_t model(input logic [2:0] k, input logic [31:0] a, input logic [31:0] b,
                                   input logic [1:0] md, input logic [2:0] rm, input logic [31:0] d);
        exp_t        e;
        int          sh;
        longint      s;
        longint      u;
        logic [31:0] r;
        logic        cf;
        logic        of;
        logic [7:0]  d8;
        int          s8;
        sh = int'(b[4:0]);
        r  = 32'h0;
        cf = 1'b0;
        of = 1'b0;
        case (k)
            OP_ADD: begin
                r  = a + b;
                u  = longint'(a) + longint'(b);
                cf = u > 64'h0000_0000_FFFF_FFFF;
                s  = longint'($signed(a)) + longint'($signed(b));
                of = (s > 64'sd2147483647) || (s < -64'sd2147483648);
            end
            OP_SUB: begin
                r  = a - b;
                cf = a < b;
                s  = longint'($signed(a)) - longint'($signed(b));
                of = (s > 64'sd2147483647) || (s < -64'sd2147483648);
            end
            OP_OR:  r = a | b;
            OP_AND: r = a & b;
            OP_XOR: r = a ^ b;
            OP_SHR: begin
                r  = a >> sh;
                cf = (sh != 0) ? a[sh-1] : 1'b0;
            end
            OP_SHL: begin
                r  = a << sh;
                cf = (sh != 0) ? a[32-sh] : 1'b0;
            end
            default: begin
                r  = 32'($signed(a) >>> sh);
                cf = (sh != 0) ? a[sh-1] : 1'b0;
            end
        endcase
        e.res   = r;
        e.flags = {of, r[31], (r == 32'h0), cf};
        d8 = d[31:24];
        s8 = int'($signed(d8));
        e.addr_v = 1'b1;
        case (md)
            2'd0:    e.addr = (rm == 3'd5) ? d : a;
            2'd1:    e.addr = a + s8;
            2'd2:    e.addr = a + d;
            default: begin
                e.addr   = 32'h0;
                e.addr_v = 1'b0;
            end
        endcase
        e.t_ready = 0;
        return e;
    endfunction

    function automatic int latency(input logic [2:0] k, input logic [31:0] b);
        int sh;
        sh = int'(b[4:0]);
        if ((k == OP_SHR || k == OP_SHL || k == OP_SAR) && sh != 0)
            return (sh + SHIFT_STEP - 1) / SHIFT_STEP + 1;
        return 1;
    endfunction

    // One clock cycle: drive at the falling edge, compare 1 ns later, update model
    task automatic step(input logic v, input logic [2:0] k, input logic [31:0] a, input logic [31:0] b,
                        input logic [1:0] md, input logic [2:0] rm, input logic [31:0] d, input logic ordy);
        logic ov_exp;
        logic rdy_exp;
        exp_t e;
        int   lat;
        in_valid  = v;
        in_aluk   = k;
        in_src1   = a;
        in_src2   = b;
        in_mod    = md;
        in_rm     = rm;
        in_disp   = d;
        out_ready = ordy;
        #1;
        ov_exp  = (q.size() > 0) && (cyc >= q[0].t_ready);
        rdy_exp = (cyc >= busy_until) && (!ov_exp || ordy);
        check("out_valid", {31'h0, out_valid}, {31'h0, ov_exp});
        check("in_ready", {31'h0, in_ready}, {31'h0, rdy_exp});
        if (ov_exp) begin
            check("result", out_result, q[0].res);
            check("addr", out_addr, q[0].addr);
            check("addr_v", {31'h0, out_addr_v}, {31'h0, q[0].addr_v});
            check("flags", {28'h0, out_flags}, {28'h0, q[0].flags});
            if (ordy) void'(q.pop_front());
        end
        if (v && rdy_exp) begin
            e          = model(k, a, b, md, rm, d);
            lat        = latency(k, b);
            e.t_ready  = cyc + lat;
            busy_until = cyc + lat;
            q.push_back(e);
        end
        @(negedge clk);
        cyc++;
    endtask

    task automatic idle(input logic ordy);
        step(1'b0, OP_ADD, $urandom, $urandom, 2'd3, 3'd0, $urandom, ordy);
    endtask

    task automatic do_reset();
        rst       = 1'b1;
        in_valid  = 1'b1;
        out_ready = 1'b1;
        #1;
        check("rst_in_ready", {31'h0, in_ready}, 32'h0);
        @(negedge clk);
        cyc++;
        check("rst_out_valid", {31'h0, out_valid}, 32'h0);
        check("rst_result", out_result, 32'h0);
        check("rst_addr", out_addr, 32'h0);
        check("rst_addr_v", {31'h0, out_addr_v}, 32'h0);
        check("rst_flags", {28'h0, out_flags}, 32'h0);
        rst      = 1'b0;
        in_valid = 1'b0;
        q.delete();
        busy_until = cyc;
    endtask

    task automatic expect_now(input string tag, input logic [31:0] res, input logic [3:0] flags);
        check({tag, "_valid"}, {31'h0, out_valid}, 32'h1);
        check({tag, "_result"}, out_result, res);
        check({tag, "_flags"}, {28'h0, out_flags}, {28'h0, flags});
    endtask

    initial begin
        rst = 1'b1; in_valid = 1'b0; in_aluk = OP_ADD; in_src1 = '0; in_src2 = '0;
        in_mod = 2'd3; in_rm = 3'd0; in_disp = '0; out_ready = 1'b0;
        @(negedge clk);
        do_reset();

        // ADD wrap to zero: ZF and CF
        step(1'b1, OP_ADD, 32'hFFFF_FFFF, 32'h1, 2'd3, 3'd0, 32'h0, 1'b1);
        expect_now("add_wrap", 32'h0, 4'b0011);
        check("add_wrap_addr_v", {31'h0, out_addr_v}, 32'h0);

        // SUB overflow, issued back-to-back every cycle
        step(1'b1, OP_SUB, 32'h8000_0000, 32'h1, 2'd3, 3'd0, 32'h0, 1'b1);
        expect_now("sub_ovf", 32'h7FFF_FFFF, 4'b1000);
        for (int i = 0; i < 4; i++)
            step(1'b1, OP_SUB, 32'h8000_0000 + i, 32'h1 + i, 2'd3, 3'd0, 32'h0, 1'b1);
        idle(1'b1);

        // SAR across three shift steps
        step(1'b1, OP_SAR, 32'h8000_0000, 32'd20, 2'd3, 3'd0, 32'h0, 1'b1);
        for (int i = 0; i < 3; i++) idle(1'b1);
        expect_now("sar20", 32'hFFFF_F800, 4'b0100);

        // Shift by zero is single-cycle; SHR by one reports carry
        step(1'b1, OP_SHL, 32'h1, 32'd0, 2'd3, 3'd0, 32'h0, 1'b1);
        expect_now("shl0", 32'h1, 4'b0000);
        step(1'b1, OP_SHR, 32'h3, 32'd1, 2'd3, 3'd0, 32'h0, 1'b1);
        idle(1'b1);
        expect_now("shr1", 32'h1, 4'b0001);

        // Effective-address forms
        step(1'b1, OP_ADD, 32'hC000_0000, 32'h0, 2'd1, 3'd0, 32'hF012_3456, 1'b1);
        check("ea_disp8", out_addr, 32'hBFFF_FFF0);
        check("ea_disp8_v", {31'h0, out_addr_v}, 32'h1);
        step(1'b1, OP_OR, 32'h1234_5678, 32'h0, 2'd0, 3'd5, 32'h00FF_00FF, 1'b1);
        check("ea_disp_only", out_addr, 32'h00FF_00FF);

        // Back-pressure: result held, new requests refused
        step(1'b1, OP_XOR, 32'hA5A5_A5A5, 32'h5A5A_5A5A, 2'd2, 3'd0, 32'h10, 1'b1);
        for (int i = 0; i < 3; i++)
            step(1'b1, OP_AND, $urandom, $urandom, 2'd0, 3'd1, 32'h0, 1'b0);
        expect_now("hold", 32'hFFFF_FFFF, 4'b0100);
        idle(1'b1);

        // Reset in the middle of a long shift
        step(1'b1, OP_SHR, 32'hFFFF_FFFF, 32'd31, 2'd3, 3'd0, 32'h0, 1'b1);
        idle(1'b1);
        idle(1'b1);
        do_reset();
        idle(1'b1);
        check("post_rst_in_ready", {31'h0, in_ready}, 32'h1);

        // Randomized traffic with random back-pressure
        for (int i = 0; i < 400; i++)
            step(1'($urandom_range(0, 3) != 0), 3'($urandom_range(0, 7)), $urandom, $urandom,
                 2'($urandom_range(0, 3)), 3'($urandom_range(0, 7)), $urandom,
                 1'($urandom_range(0, 3) != 0));
        for (int i = 0; i < 8; i++) idle(1'b1);
        check("drained", q.size(), 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
